ild1420_cmd_tx: RTL and testbench

ILD1420_CMD_TX -- requirements
Module: ild1420_cmd_tx

---
 rtl/ild1420_cmd_tx.sv | 139 +++++++++++++
 tb/tb_ild1420_cmd_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ild1420_cmd_tx.sv
// ILD1420 host-to-sensor command transmitter: byte FIFO drained as back-to-back 8N1 frames.
// Optional CR/LF terminator appended to every command when ILD1420_CMD_AUTO_CRLF_EN is defined.
module ild1420_cmd_tx #(
  parameter int unsigned CLK_DIV = 217,
  parameter int unsigned DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       send,
  output logic       dout,
  output logic       busy,
  output logic       full,
  output logic       overflow,
  output logic       done
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, next_state;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tick, wr_accept, wr_drop, send_ok, pending, pop;
  logic [7:0]    next_byte;

  assign tick      = (div_cnt == DW'(CLK_DIV - 1));
  assign busy      = (state != IDLE);
  assign full      = (count == CW'(DEPTH));
  assign wr_accept = wr_en && (state == IDLE) && !full;
  assign wr_drop   = wr_en && !wr_accept;
  assign pop       = (state == START) && tick && (count != '0);

`ifdef ILD1420_CMD_AUTO_CRLF_EN
  logic [1:0] term_left;

  assign pending   = (count != '0) || (term_left != 2'd0);
  assign next_byte = (count != '0) ? mem[rd_ptr] : ((term_left == 2'd2) ? 8'h0D : 8'h0A);
  assign send_ok   = (state == IDLE) && send;

  // Terminator bytes are only consumed once the FIFO has drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_left <= 2'd0;
    end else if (send_ok) begin
      term_left <= 2'd2;
    end else if ((state == START) && tick && (count == '0) && (term_left != 2'd0)) begin
      term_left <= term_left - 2'd1;
    end
  end
`else
  assign pending   = (count != '0);
  assign next_byte = mem[rd_ptr];
  // A byte written in the same cycle as send counts as pending.
  assign send_ok   = (state == IDLE) && send && ((count != '0) || wr_accept);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (send_ok) next_state = START;
      START: if (tick) next_state = DATA;
      DATA:  if (tick && (bit_cnt == 3'd7)) next_state = STOP;
      STOP:  if (tick) next_state = pending ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)       rd_ptr <= rd_ptr + PW'(1);
      if (wr_accept && !pop)      count <= count + CW'(1);
      else if (pop && !wr_accept) count <= count - CW'(1);
      if (wr_drop)      overflow <= 1'b1;
      else if (send_ok) overflow <= 1'b0;
    end
  end

  // The byte is fetched at the end of the start bit, so a same-cycle write is already stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      dout    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == IDLE) || tick) div_cnt <= '0;
      else                         div_cnt <= div_cnt + DW'(1);
      unique case (state)
        IDLE: if (send_ok) dout <= 1'b0;
        START: if (tick) begin
          shreg   <= next_byte;
          dout    <= next_byte[0];
          bit_cnt <= '0;
        end
        DATA: if (tick) begin
          if (bit_cnt == 3'd7) begin
            dout <= 1'b1;
          end else begin
            shreg   <= shreg >> 1;
            dout    <= shreg[1];
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        STOP: if (tick) begin
          if (pending) dout <= 1'b0;
          else         done <= 1'b1;
        end
        default: dout <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_ild1420_cmd_tx.sv
// Bench for ild1420_cmd_tx: per-cycle line/flag model driven by a frame queue, plus a UART receiver.
module tb_ild1420_cmd_tx;

  localparam int unsigned DIV = 16;
  localparam int unsigned DEP = 16;
`ifdef ILD1420_CMD_AUTO_CRLF_EN
  localparam int TERM = 2;
`else
  localparam int TERM = 0;
`endif
  localparam int BOUND = 200 * DIV + 100;

  logic       clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, send = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       dout, busy, full, overflow, done;

  int total = 0, bad = 0;
  bit chk_en = 1'b0;

  ild1420_cmd_tx #(.CLK_DIV(DIV), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .send(send),
    .dout(dout), .busy(busy), .full(full), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted send expands the buffered bytes into one expected line level per cycle.
  bit          line_q[$];
  byte unsigned mfifo[$];
  bit m_busy = 1'b0, m_dout = 1'b1, m_done = 1'b0, m_ovf = 1'b0;

  function automatic void push_frame(input byte unsigned b);
    for (int i = 0; i < int'(DIV); i++) line_q.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < int'(DIV); i++) line_q.push_back(b[k]);
    for (int i = 0; i < int'(DIV); i++) line_q.push_back(1'b1);
  endfunction

  always @(posedge clk) begin
    bit idle, drop;
    if (!rst_n) begin
      line_q.delete(); mfifo.delete();
      m_busy = 1'b0; m_dout = 1'b1; m_done = 1'b0; m_ovf = 1'b0;
    end else begin
      idle = !m_busy;
      drop = 1'b0;
      if (wr_en) begin
        if (idle && mfifo.size() < DEP) mfifo.push_back(wr_data);
        else drop = 1'b1;
      end
      if (send && idle && (mfifo.size() > 0 || TERM > 0)) begin
        foreach (mfifo[i]) push_frame(mfifo[i]);
        if (TERM > 0) begin push_frame(8'h0D); push_frame(8'h0A); end
        mfifo.delete();
        m_ovf = 1'b0;
      end
      if (drop) m_ovf = 1'b1;
      if (line_q.size() > 0) begin
        m_dout = line_q.pop_front(); m_done = 1'b0; m_busy = 1'b1;
      end else begin
        m_done = m_busy; m_busy = 1'b0; m_dout = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("dout", dout, m_dout);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("overflow", overflow, m_ovf);
      if (!m_busy) chk("full", full, (mfifo.size() == DEP));
    end
  end

  // Independent receiver: mid-bit sampling of the serial line.
  byte unsigned rx_q[$];
  initial begin
    byte unsigned b;
    forever begin
      @(negedge clk);
      if (rst_n && dout === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        if (dout === 1'b0) begin
          for (int k = 0; k < 8; k++) begin
            repeat (DIV) @(negedge clk);
            b[k] = dout;
          end
          repeat (DIV) @(negedge clk);
          rx_q.push_back(b);
        end
      end
    end
  end

  bit cap[$];

  task automatic wait_done(output int got);
    got = -1;
    cap.delete();
    cap.push_back(1'b1);
    for (int n = 1; n <= BOUND; n++) begin
      @(negedge clk);
      send = 1'b0; wr_en = 1'b0;
      cap.push_back(dout);
      if (done === 1'b1) begin got = n; break; end
    end
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    int got, quiet;
    byte unsigned exp_rx[$];
    byte unsigned rb;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_dout", dout, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // 'I','D' written on the first edges after reset release
    wr_byte(8'h49);
    wr_byte(8'h44);
    send = 1'b1;
    wait_done(got);
    chk("id_done_cycle", got, (20 + 10 * TERM) * DIV + 1);
    chk("id_busy_at_done", busy, 1'b0);
    chk("id_start_bit", cap[1], 1'b0);
    chk("id_b0_bit0", cap[DIV + DIV / 2], 1'b1);
    chk("id_b0_bit1", cap[2 * DIV + DIV / 2], 1'b0);
    chk("id_b0_bit3", cap[4 * DIV + DIV / 2], 1'b1);
    chk("id_b0_stop", cap[10 * DIV - DIV / 2], 1'b1);
    chk("id_b1_start", cap[10 * DIV + DIV / 2], 1'b0);
    chk("id_b1_bit2", cap[13 * DIV + DIV / 2], 1'b1);
    chk("id_b1_bit3", cap[14 * DIV + DIV / 2], 1'b0);
    @(negedge clk);
    chk("id_done_pulse", done, 1'b0);

    // send with nothing buffered
    send = 1'b1;
`ifdef ILD1420_CMD_AUTO_CRLF_EN
    wait_done(got);
    chk("empty_crlf_cycle", got, 20 * DIV + 1);
`else
    @(negedge clk);
    send = 1'b0;
    quiet = 0;
    for (int n = 0; n < 1000; n++) begin
      if (dout === 1'b1 && busy === 1'b0 && done === 1'b0) quiet++;
      @(negedge clk);
    end
    chk("empty_quiet", quiet, 1000);
`endif

    // write and send in the same cycle
    wr_en = 1'b1; wr_data = 8'h52; send = 1'b1;
    wait_done(got);
    chk("same_cycle_done", got, (10 + 10 * TERM) * DIV + 1);
    chk("same_cycle_bit0", cap[DIV + DIV / 2], 1'b0);
    chk("same_cycle_bit1", cap[2 * DIV + DIV / 2], 1'b1);

    // fill, overflow, send clears overflow
    for (int i = 0; i < int'(DEP); i++) wr_byte(8'h30 + 8'(i));
    chk("full_after_16", full, 1'b1);
    chk("no_ovf_at_16", overflow, 1'b0);
    wr_byte(8'h7A);
    chk("ovf_after_17", overflow, 1'b1);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    chk("ovf_cleared_by_send", overflow, 1'b0);
    wait_done(got);
    chk("full_done_cycle", got + 1, (10 * int'(DEP) + 10 * TERM) * DIV + 1);

    // write and send while busy are dropped / ignored
    wr_byte(8'h41);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (4) @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h55; send = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; send = 1'b0;
    chk("busy_write_ovf", overflow, 1'b1);
    wait_done(got);
    chk("busy_done_cycle", got + 6, (10 + 10 * TERM) * DIV + 1);
    chk("ovf_sticky", overflow, 1'b1);

    // reset in the data bits of the second byte
    wr_byte(8'h31);
    wr_byte(8'h32);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (13 * DIV - 1) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_dout", dout, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_full", full, 1'b0);
    chk("midrst_ovf", overflow, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (12 * DIV) @(negedge clk);
`ifndef ILD1420_CMD_AUTO_CRLF_EN
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    #1 chk("rst_fifo_empty", busy, 1'b0);
    @(negedge clk);
`endif
    wr_byte(8'h41);
    send = 1'b1;
    wait_done(got);
    chk("post_rst_done", got, (10 + 10 * TERM) * DIV + 1);
    chk("post_rst_bit0", cap[DIV + DIV / 2], 1'b1);
    chk("post_rst_bit1", cap[2 * DIV + DIV / 2], 1'b0);

    // 50 random bytes through the receiver
    repeat (4) @(negedge clk);
    rx_q.delete();
    for (int batch = 0; batch < 5; batch++) begin
      for (int i = 0; i < 10; i++) begin
        rb = 8'($urandom_range(0, 255));
        exp_rx.push_back(rb);
        wr_byte(rb);
      end
      if (TERM > 0) begin exp_rx.push_back(8'h0D); exp_rx.push_back(8'h0A); end
      send = 1'b1;
      wait_done(got);
      chk("rand_done_cycle", got, (100 + 10 * TERM) * DIV + 1);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("rx_count", rx_q.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++)
      chk("rx_byte", rx_q[i], exp_rx[i]);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
